// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: RV32I load/store funct3
// encodings and the access FSM state type.
package dmem_responder_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/dmem_responder_align.sv
// Byte-lane merge for stores, lane extract and extension for loads, and the
// access legality check (alignment and funct3).
module dmem_align
    import dmem_responder_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              we,
    input  logic [2:0]        funct3,
    input  logic [1:0]        addr_lo,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] word_in,
    output logic [DATA_W-1:0] word_out,
    output logic [DATA_W-1:0] rdata,
    output logic              err
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        err = 1'b1;
        case (funct3)
            F3_LB:   err = 1'b0;
            F3_LH:   err = addr_lo[0];
            F3_LW:   err = (addr_lo != 2'b00);
            F3_LBU:  err = we;
            F3_LHU:  err = we | addr_lo[0];
            default: err = 1'b1;
        endcase
    end

    always_comb begin
        word_out = word_in;
        case (funct3)
            F3_SB:   word_out[{addr_lo, 3'b000} +: 8]     = wdata[7:0];
            F3_SH:   word_out[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
            F3_SW:   word_out = wdata;
            default: word_out = word_in;
        endcase
    end

    always_comb begin
        byte_v = word_in[{addr_lo, 3'b000} +: 8];
        half_v = word_in[{addr_lo[1], 4'b0000} +: 16];
        rdata  = '0;
        // stores and rejected accesses always report zero data
        if (!we && !err) begin
            case (funct3)
                F3_LB:   rdata = {{(DATA_W-8){byte_v[7]}}, byte_v};
                F3_LH:   rdata = {{(DATA_W-16){half_v[15]}}, half_v};
                F3_LW:   rdata = word_in;
                F3_LBU:  rdata = {{(DATA_W-8){1'b0}}, byte_v};
                F3_LHU:  rdata = {{(DATA_W-16){1'b0}}, half_v};
                default: rdata = '0;
            endcase
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Single-port data memory with a valid/ready request side, a programmable
// number of wait states and a one-cycle registered response strobe.
//
// state   | meaning
// IDLE    | ready for a request, req_ready high
// WAIT    | counting down wait states for the captured request
// RESP    | rsp_valid high for one cycle; write committed on entry
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32,
    parameter int WAIT_CYC   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [DM_ADDRESS-1:0] req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [2:0]            req_funct3,
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err
);

    localparam int         DEPTH     = 2 ** (DM_ADDRESS - 2);
    localparam logic [3:0] WAIT_LOAD = 4'((WAIT_CYC > 0) ? WAIT_CYC - 1 : 0);

    state_t                state, state_nxt;
    logic [3:0]            cnt, cnt_nxt;
    logic                  ready_nxt, valid_nxt, err_nxt;
    logic [DATA_W-1:0]     rdata_nxt;

    logic                  cap_we;
    logic [DM_ADDRESS-1:0] cap_addr;
    logic [DATA_W-1:0]     cap_wdata;
    logic [2:0]            cap_funct3;

    logic                  acc_we;
    logic [DM_ADDRESS-1:0] acc_addr;
    logic [DATA_W-1:0]     acc_wdata;
    logic [2:0]            acc_funct3;

    logic [DATA_W-1:0]     mem [DEPTH];
    logic [DATA_W-1:0]     word_rd, word_wr, ld_data;
    logic                  ld_err;
    logic                  handshake, enter_resp, mem_we;

    assign handshake = (state == ST_IDLE) && req_ready && req_valid;

    // With zero wait states RESP is entered on the handshake edge itself,
    // so the live request feeds the datapath while in IDLE.
    always_comb begin
        if (state == ST_IDLE) begin
            acc_we     = req_we;
            acc_addr   = req_addr;
            acc_wdata  = req_wdata;
            acc_funct3 = req_funct3;
        end else begin
            acc_we     = cap_we;
            acc_addr   = cap_addr;
            acc_wdata  = cap_wdata;
            acc_funct3 = cap_funct3;
        end
    end

    assign word_rd = mem[acc_addr[DM_ADDRESS-1:2]];

    dmem_align #(.DATA_W(DATA_W)) u_align (
        .we       (acc_we),
        .funct3   (acc_funct3),
        .addr_lo  (acc_addr[1:0]),
        .wdata    (acc_wdata),
        .word_in  (word_rd),
        .word_out (word_wr),
        .rdata    (ld_data),
        .err      (ld_err)
    );

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        ready_nxt  = req_ready;
        valid_nxt  = 1'b0;
        err_nxt    = 1'b0;
        rdata_nxt  = '0;
        enter_resp = 1'b0;
        case (state)
            ST_IDLE: begin
                ready_nxt = 1'b1;
                if (handshake) begin
                    ready_nxt = 1'b0;
                    if (WAIT_CYC == 0) begin
                        enter_resp = 1'b1;
                    end else begin
                        state_nxt = ST_WAIT;
                        cnt_nxt   = WAIT_LOAD;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt == 4'd0) enter_resp = 1'b1;
                else             cnt_nxt    = cnt - 4'd1;
            end
            ST_RESP: begin
                state_nxt = ST_IDLE;
                ready_nxt = 1'b1;
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (enter_resp) begin
            state_nxt = ST_RESP;
            valid_nxt = 1'b1;
            rdata_nxt = ld_data;
            err_nxt   = ld_err;
        end
    end

    assign mem_we = enter_resp && acc_we && !ld_err && !reset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            cnt        <= 4'd0;
            req_ready  <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
            cap_we     <= 1'b0;
            cap_addr   <= '0;
            cap_wdata  <= '0;
            cap_funct3 <= 3'b000;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            req_ready <= ready_nxt;
            rsp_valid <= valid_nxt;
            rsp_rdata <= rdata_nxt;
            rsp_err   <= err_nxt;
            if (handshake) begin
                cap_we     <= req_we;
                cap_addr   <= req_addr;
                cap_wdata  <= req_wdata;
                cap_funct3 <= req_funct3;
            end
        end
    end

    // Array is intentionally outside the reset domain so contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) mem[acc_addr[DM_ADDRESS-1:2]] <= word_wr;
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances with 1, 0 and 15 wait
// states, hand-computed expected data, latency and handshake timing.
module tb_dmem_responder;

    logic             clk = 1'b0;
    logic             reset;
    logic [2:0]       req_valid, req_we, req_ready, rsp_valid, rsp_err;
    logic [2:0][8:0]  req_addr;
    logic [2:0][31:0] req_wdata, rsp_rdata;
    logic [2:0][2:0]  req_funct3;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    dmem_responder #(.WAIT_CYC(1)) u_w1 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_funct3(req_funct3[0]),
        .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]));

    dmem_responder #(.WAIT_CYC(0)) u_w0 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_funct3(req_funct3[1]),
        .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]));

    dmem_responder #(.WAIT_CYC(15)) u_w15 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[2]), .req_ready(req_ready[2]), .req_we(req_we[2]),
        .req_addr(req_addr[2]), .req_wdata(req_wdata[2]), .req_funct3(req_funct3[2]),
        .rsp_valid(rsp_valid[2]), .rsp_rdata(rsp_rdata[2]), .rsp_err(rsp_err[2]));

    function automatic int wc_of(input int d);
        case (d)
            0:       return 1;
            1:       return 0;
            default: return 15;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One request on instance d; checks latency, ready/valid shape, returns response.
    task automatic access(input int d, input string tag, input logic we, input logic [2:0] f3,
                          input logic [8:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err);
        int  guard;
        int  k;
        bit  seen;
        bit  ready_hi;
        @(negedge clk);
        req_valid[d] = 1'b1; req_we[d] = we; req_funct3[d] = f3;
        req_addr[d] = addr;  req_wdata[d] = wdata;
        guard = 0;
        while (!req_ready[d] && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk({tag, "_hs"}, 32'(guard < 50), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid[d] = 1'b0;
        k = 1; seen = 1'b0; ready_hi = 1'b0;
        while (k <= 40 && !seen) begin
            if (rsp_valid[d]) begin
                seen = 1'b1;
            end else begin
                if (req_ready[d]) ready_hi = 1'b1;
                @(negedge clk);
                k++;
            end
        end
        chk({tag, "_lat"}, 32'(k), 32'(wc_of(d) + 1));
        rdata = rsp_rdata[d];
        err   = rsp_err[d];
        chk({tag, "_rdy_lo"}, 32'(ready_hi | req_ready[d]), 32'd0);
        @(negedge clk);
        chk({tag, "_one_shot"}, 32'(rsp_valid[d]), 32'd0);
        chk({tag, "_rdy_back"}, 32'(req_ready[d]), 32'd1);
    endtask

    // Hold req_valid continuously; responses must land at W+1 and 2W+3.
    task automatic back_to_back(input int d, input string tag);
        int w;
        int p1;
        int p2;
        int npulse;
        int nrdy;
        w = wc_of(d);
        p1 = 0; p2 = 0; npulse = 0; nrdy = 0;
        @(negedge clk);
        req_valid[d] = 1'b1; req_we[d] = 1'b0; req_funct3[d] = 3'b010;
        req_addr[d] = 9'h000; req_wdata[d] = 32'h0;
        @(posedge clk);
        for (int k = 1; k <= 2 * w + 4; k++) begin
            @(negedge clk);
            if (rsp_valid[d]) begin
                npulse++;
                if (npulse == 1) p1 = k;
                if (npulse == 2) p2 = k;
            end
            if (req_ready[d]) nrdy++;
        end
        req_valid[d] = 1'b0;
        chk({tag, "_npulse"}, 32'(npulse), 32'd2);
        chk({tag, "_p1"}, 32'(p1), 32'(w + 1));
        chk({tag, "_p2"}, 32'(p2), 32'(2 * w + 3));
        chk({tag, "_rdy_cycles"}, 32'(nrdy), 32'd2);
        repeat (2) @(negedge clk);
    endtask

    logic [31:0] rd;
    logic        er;
    int          nv;

    initial begin
        reset = 1'b1;
        req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0; req_funct3 = '0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk("rst_ready", 32'(req_ready[d]), 32'd0);
            chk("rst_valid", 32'(rsp_valid[d]), 32'd0);
            chk("rst_rdata", rsp_rdata[d], 32'd0);
            chk("rst_err",   32'(rsp_err[d]), 32'd0);
        end
        reset = 1'b0;
        #1 chk("rdy_before_edge", 32'(req_ready[0]), 32'd0);
        @(negedge clk);
        chk("rdy_rise", 32'(req_ready[0]), 32'd1);

        access(0, "sw_dead", 1'b1, 3'b010, 9'h010, 32'hDEADBEEF, rd, er);
        chk("sw_dead_rdata", rd, 32'd0);
        chk("sw_dead_err", 32'(er), 32'd0);
        access(0, "lw_dead", 1'b0, 3'b010, 9'h010, 32'h0, rd, er);
        chk("lw_dead_rdata", rd, 32'hDEADBEEF);
        chk("lw_dead_err", 32'(er), 32'd0);

        access(0, "sw_base", 1'b1, 3'b010, 9'h010, 32'h11223344, rd, er);
        access(0, "sb_80", 1'b1, 3'b000, 9'h013, 32'h00000080, rd, er);
        chk("sb_80_err", 32'(er), 32'd0);
        access(0, "lb_13", 1'b0, 3'b000, 9'h013, 32'h0, rd, er);
        chk("lb_13_rdata", rd, 32'hFFFFFF80);
        access(0, "lbu_13", 1'b0, 3'b100, 9'h013, 32'h0, rd, er);
        chk("lbu_13_rdata", rd, 32'h00000080);
        access(0, "lw_merged", 1'b0, 3'b010, 9'h010, 32'h0, rd, er);
        chk("lw_merged_rdata", rd, 32'h80223344);

        access(0, "sh_mis", 1'b1, 3'b001, 9'h011, 32'h0000BEEF, rd, er);
        chk("sh_mis_err", 32'(er), 32'd1);
        chk("sh_mis_rdata", rd, 32'd0);
        access(0, "lw_mis", 1'b0, 3'b010, 9'h012, 32'h0, rd, er);
        chk("lw_mis_err", 32'(er), 32'd1);
        chk("lw_mis_rdata", rd, 32'd0);
        access(0, "lw_after_mis", 1'b0, 3'b010, 9'h010, 32'h0, rd, er);
        chk("lw_after_mis_rdata", rd, 32'h80223344);

        access(0, "lh_12", 1'b0, 3'b001, 9'h012, 32'h0, rd, er);
        chk("lh_12_rdata", rd, 32'hFFFF8022);
        access(0, "lhu_10", 1'b0, 3'b101, 9'h010, 32'h0, rd, er);
        chk("lhu_10_rdata", rd, 32'h00003344);
        access(0, "sh_12", 1'b1, 3'b001, 9'h012, 32'h1234A5A5, rd, er);
        access(0, "lw_sh", 1'b0, 3'b010, 9'h010, 32'h0, rd, er);
        chk("lw_sh_rdata", rd, 32'hA5A53344);

        access(0, "ld_f3_011", 1'b0, 3'b011, 9'h010, 32'h0, rd, er);
        chk("ld_f3_011_err", 32'(er), 32'd1);
        chk("ld_f3_011_rdata", rd, 32'd0);
        access(0, "st_f3_100", 1'b1, 3'b100, 9'h010, 32'hFFFFFFFF, rd, er);
        chk("st_f3_100_err", 32'(er), 32'd1);
        access(0, "lw_nowrite", 1'b0, 3'b010, 9'h010, 32'h0, rd, er);
        chk("lw_nowrite_rdata", rd, 32'hA5A53344);
        chk("lw_nowrite_err", 32'(er), 32'd0);

        // reset lands in WAIT: the store must be dropped and no response seen
        access(0, "sw_prior", 1'b1, 3'b010, 9'h020, 32'hCAFEF00D, rd, er);
        @(negedge clk);
        req_valid[0] = 1'b1; req_we[0] = 1'b1; req_funct3[0] = 3'b010;
        req_addr[0] = 9'h020; req_wdata[0] = 32'h12345678;
        @(posedge clk);
        @(negedge clk);
        req_valid[0] = 1'b0;
        reset = 1'b1;
        nv = 0;
        for (int k = 0; k < 4; k++) begin
            #1 if (rsp_valid[0]) nv++;
            @(negedge clk);
        end
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (rsp_valid[0]) nv++;
        end
        chk("abort_no_rsp", 32'(nv), 32'd0);
        chk("abort_ready", 32'(req_ready[0]), 32'd1);
        access(0, "lw_prior", 1'b0, 3'b010, 9'h020, 32'h0, rd, er);
        chk("lw_prior_rdata", rd, 32'hCAFEF00D);

        access(1, "w0_sw", 1'b1, 3'b010, 9'h004, 32'h0BADF00D, rd, er);
        access(1, "w0_lw", 1'b0, 3'b010, 9'h004, 32'h0, rd, er);
        chk("w0_lw_rdata", rd, 32'h0BADF00D);
        back_to_back(1, "w0_b2b");

        access(2, "w15_sw", 1'b1, 3'b010, 9'h1FC, 32'h5A5A0FF0, rd, er);
        access(2, "w15_lb", 1'b0, 3'b000, 9'h1FD, 32'h0, rd, er);
        chk("w15_lb_rdata", rd, 32'h0000000F);
        back_to_back(2, "w15_b2b");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
